aa_stream_filter: RTL and testbench
===================================

# aa_stream_filter

Streaming, parametrised edge-smoothing filter for the anti-aliasing path. It accepts a raster-order pixel stream over a valid/ready handshake and buffers two lines internally. Each interior pixel above threshold that touches a pixel at or below threshold is replaced by a centre-weighted neighbourhood average; every other pixel passes unchanged. It sits between the frame source and the display/output stage, and emits exactly one output pixel per input pixel in the same raster order.

## Interface
- PIX_W, 8: pixel width in bits (grayscale)
- IMG_W, 640: pixels per line, ≥ 4
- IMG_H, 480: lines per frame, ≥ 3
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- th  in  PIX_W  edge threshold; sampled when s_sof is accepted, held for the frame
- s_valid  in  1  input pixel valid
- s_ready  out  1  block accepts input pixel
- s_data  in  PIX_W  input pixel
- s_sof  in  1  first pixel of frame, qualified by s_valid
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts output pixel
- m_data  out  PIX_W  output pixel
- m_sof  out  1  first output pixel of frame
- m_eol  out  1  last pixel of each output line
- done  out  1  one-cycle pulse when the last output pixel of a frame is accepted

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE → RUN on an accepted pixel with s_sof=1. Pixels without s_sof are accepted in IDLE and discarded.
  - RUN → FLUSH after input pixel IMG_W*IMG_H-1 is accepted.
  - FLUSH → IDLE after the last output pixel is accepted.
- Input counters: col 0..IMG_W-1, row 0..IMG_H-1. col wraps to 0 and increments row.
- An accepted s_sof in RUN or FLUSH aborts the frame. The pipeline is cleared, no done pulse is issued, and the pixel is taken as (0,0) of a new frame.
- Neighbourhood: centre C and neighbours N, S, E, W, taken from two line buffers plus column shift registers.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) always pass C unchanged.
- Edge condition: C > th and at least one neighbour ≤ th. Comparison is unsigned.
- Edge output: (4·C + N + S + E + W) >> 3. Accumulate at PIX_W+3 bits and truncate; no rounding. The result never exceeds the maximum PIX_W value.
- Non-edge output: C.

## Timing
- Reset values:
  - s_ready=0 while reset_n=0; 1 in IDLE after release.
  - m_valid=0, m_data=0, m_sof=0, m_eol=0, done=0.
  - State IDLE; counters 0; line-buffer contents don't-care.
- Output pixel k (raster index) is registered one cycle after input pixel k+IMG_W+1 is accepted.
- In FLUSH the remaining IMG_W+1 outputs are produced at one per cycle while m_ready=1.
- s_ready = (state≠FLUSH) && (!m_valid || m_ready).
- Backpressure stalls the whole pipeline. While m_valid=1 and m_ready=0, m_data, m_sof and m_eol stay stable.
- done is asserted in the cycle after the final m_valid&&m_ready handshake.
- Asserting reset_n mid-frame clears all outputs immediately. Partial frame data is discarded.
- Throughput: 1 pixel/cycle with continuous valid and ready.

## Configuration
- AA_DIAG_EN defined: 3×3 neighbourhood including the four diagonals.
  - Edge test covers all 8 neighbours.
  - Output = (8·C + sum of 8 neighbours) >> 4, with a PIX_W+4 bit accumulator.
  - Latency and borders unchanged.
- AA_DIAG_EN undefined: 5-point cross as specified above. No diagonal registers are instantiated.

## Structure
- Package aa_pkg holds:
  - state enum (IDLE, RUN, FLUSH)
  - ACC_W constant function of PIX_W, accounting for AA_DIAG_EN
  - counter width function clog2(IMG_W) / clog2(IMG_H)
- Sub-module aa_line_buf: IMG_W-deep, PIX_W-wide delay line with shift-enable, instantiated twice.

## Test plan
Bench configuration: IMG_W=4, IMG_H=4, PIX_W=8, th=100, m_ready=1 unless stated.
- Uniform frame of 50 → 16 outputs of 50; m_eol on outputs 3, 7, 11, 15; m_sof on output 0; done one cycle after output 15.
- All zeros except (1,1)=200 → output (1,1)=100; all other outputs 0.
- Uniform frame of 200 → all outputs 200 (no edge detected).
- m_ready held low for 5 cycles after output 6 is presented → m_data stable, s_ready=0, no pixel lost or duplicated; all 16 outputs correct.
- reset_n pulsed low after input 9 → all outputs 0 immediately; next full frame matches the uniform-frame case exactly.
- AA_DIAG_EN build, (1,1)=200, others 0 → output (1,1)=100; all other outputs 0.

Source files
------------

// File: rtl/aa_pkg.sv
// Shared types and sizing helpers for the aa_stream_filter slice.
// AA_DIAG_EN selects the 3x3 neighbourhood width/shift; otherwise the 5-point cross.
package aa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } aa_state_e;

`ifdef AA_DIAG_EN
    localparam int unsigned AA_SHIFT = 4;
`else
    localparam int unsigned AA_SHIFT = 3;
`endif

    function automatic int unsigned acc_w(input int unsigned pix_w);
        return pix_w + AA_SHIFT;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aa_line_buf.sv
// DEPTH-deep pixel delay line: dout is the value written DEPTH enabled cycles earlier.
// Circular buffer so storage can map to RAM; contents are intentionally not reset.
module aa_line_buf
    import aa_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned DEPTH = 640
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    localparam int unsigned PTR_W = cnt_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= din;
        end
    end

    assign dout = mem[ptr_q];

endmodule

// File: rtl/aa_stream_filter.sv
// Streaming edge-smoothing filter: two line buffers + column registers form the window.
// Define AA_DIAG_EN for the 3x3 neighbourhood; default build is the 5-point cross.
module aa_stream_filter
    import aa_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] th,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             done
);

    localparam int unsigned ACC_W = acc_w(PIX_W);
    localparam int unsigned CW    = cnt_w(IMG_W);
    localparam int unsigned RW    = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    aa_state_e state_q, state_d;

    logic [CW-1:0]    col_q, col_d, ocol_q, ocol_d;
    logic [RW-1:0]    row_q, row_d, orow_q, orow_d;
    logic             gen_done_q, gen_done_d;
    logic [PIX_W-1:0] th_q, th_d;

    logic             m_valid_q, m_valid_d;
    logic [PIX_W-1:0] m_data_q, m_data_d;
    logic             m_sof_q, m_sof_d;
    logic             m_eol_q, m_eol_d;
    logic             m_last_q, m_last_d;
    logic             done_q, done_d;

    // Window columns: b* = incoming row, m* = centre row, t* = row above.
    logic [PIX_W-1:0] b1_q, b1_d, m1_q, m1_d, m2_q, m2_d, t1_q, t1_d;
`ifdef AA_DIAG_EN
    logic [PIX_W-1:0] b2_q, b2_d, t2_q, t2_d;
`endif

    logic             out_en, accept, sof_acc, px_acc, flush_step, adv, gen;
    logic             in_last, out_last, past_lag;
    logic [PIX_W-1:0] shift_in, lb1_dout, lb2_dout;
    logic [PIX_W-1:0] px_c, px_n, px_s, px_e, px_w, filt;
    logic             border, nb_low, edge_hit;
    logic [ACC_W-1:0] acc;

    aa_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .din     (shift_in),
        .dout    (lb1_dout)
    );

    aa_line_buf #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .din     (lb1_dout),
        .dout    (lb2_dout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sof_acc) state_d = RUN;
            RUN:     if (px_acc && in_last) state_d = FLUSH;
            FLUSH:   if (m_valid_q && m_ready && m_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A generated output always reflects input k+IMG_W+1; FLUSH feeds dummy
    // pixels so the remaining (all border) outputs drain out of the window.
    always_comb begin
        out_en     = !m_valid_q || m_ready;
        s_ready    = reset_n && (state_q != FLUSH) && out_en;
        accept     = s_valid && s_ready;
        sof_acc    = accept && s_sof;
        px_acc     = accept && !s_sof && (state_q == RUN);
        flush_step = (state_q == FLUSH) && out_en && !gen_done_q;
        adv        = sof_acc || px_acc || flush_step;
        in_last    = (row_q == ROW_LAST) && (col_q == COL_LAST);
        out_last   = (orow_q == ROW_LAST) && (ocol_q == COL_LAST);
        past_lag   = (row_q > RW'(1)) || ((row_q == RW'(1)) && (col_q != '0));
        gen        = (px_acc && past_lag) || flush_step;
        shift_in   = (state_q == FLUSH) ? '0 : s_data;
    end

    always_comb begin
        px_c   = m1_q;
        px_n   = t1_q;
        px_s   = b1_q;
        px_e   = lb1_dout;
        px_w   = m2_q;
        border = (orow_q == '0) || (orow_q == ROW_LAST) ||
                 (ocol_q == '0) || (ocol_q == COL_LAST);
        nb_low = (px_n <= th_q) || (px_s <= th_q) || (px_e <= th_q) || (px_w <= th_q);
        acc    = (ACC_W'(px_c) << (AA_SHIFT - 1)) + ACC_W'(px_n) + ACC_W'(px_s) +
                 ACC_W'(px_e) + ACC_W'(px_w);
`ifdef AA_DIAG_EN
        nb_low = nb_low || (t2_q <= th_q) || (lb2_dout <= th_q) ||
                 (b2_q <= th_q) || (shift_in <= th_q);
        acc    = acc + ACC_W'(t2_q) + ACC_W'(lb2_dout) + ACC_W'(b2_q) + ACC_W'(shift_in);
`endif
        edge_hit = (px_c > th_q) && nb_low;
        filt     = (border || !edge_hit) ? px_c : PIX_W'(acc >> AA_SHIFT);
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        ocol_d     = ocol_q;
        orow_d     = orow_q;
        gen_done_d = gen_done_q;
        th_d       = th_q;
        if (sof_acc) begin
            col_d      = CW'(1);
            row_d      = '0;
            ocol_d     = '0;
            orow_d     = '0;
            gen_done_d = 1'b0;
            th_d       = th;
        end else begin
            if (px_acc) begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = in_last ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (gen) begin
                if (ocol_q == COL_LAST) begin
                    ocol_d = '0;
                    orow_d = out_last ? '0 : orow_q + 1'b1;
                end else begin
                    ocol_d = ocol_q + 1'b1;
                end
                if (out_last) gen_done_d = 1'b1;
            end
        end
    end

    always_comb begin
        b1_d = b1_q;
        m1_d = m1_q;
        m2_d = m2_q;
        t1_d = t1_q;
`ifdef AA_DIAG_EN
        b2_d = b2_q;
        t2_d = t2_q;
`endif
        if (adv) begin
            b1_d = shift_in;
            m1_d = lb1_dout;
            m2_d = m1_q;
            t1_d = lb2_dout;
`ifdef AA_DIAG_EN
            b2_d = b1_q;
            t2_d = t1_q;
`endif
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sof_d   = m_sof_q;
        m_eol_d   = m_eol_q;
        m_last_d  = m_last_q;
        done_d    = m_valid_q && m_ready && m_last_q;
        if (sof_acc) begin
            m_valid_d = 1'b0;
        end else if (gen) begin
            m_valid_d = 1'b1;
            m_data_d  = filt;
            m_sof_d   = (orow_q == '0) && (ocol_q == '0);
            m_eol_d   = (ocol_q == COL_LAST);
            m_last_d  = out_last;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            ocol_q     <= '0;
            orow_q     <= '0;
            gen_done_q <= 1'b0;
            th_q       <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_sof_q    <= 1'b0;
            m_eol_q    <= 1'b0;
            m_last_q   <= 1'b0;
            done_q     <= 1'b0;
            b1_q       <= '0;
            m1_q       <= '0;
            m2_q       <= '0;
            t1_q       <= '0;
`ifdef AA_DIAG_EN
            b2_q       <= '0;
            t2_q       <= '0;
`endif
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            ocol_q     <= ocol_d;
            orow_q     <= orow_d;
            gen_done_q <= gen_done_d;
            th_q       <= th_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_sof_q    <= m_sof_d;
            m_eol_q    <= m_eol_d;
            m_last_q   <= m_last_d;
            done_q     <= done_d;
            b1_q       <= b1_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            t1_q       <= t1_d;
`ifdef AA_DIAG_EN
            b2_q       <= b2_d;
            t2_q       <= t2_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sof   = m_sof_q;
    assign m_eol   = m_eol_q;
    assign done    = done_q;

endmodule

// File: tb/tb_aa_stream_filter.sv
// Scoreboard bench for aa_stream_filter on a 4x4 frame, th=100.
// Honours AA_DIAG_EN in its reference model.
module tb_aa_stream_filter;

    localparam int W = 4;
    localparam int H = 4;
    localparam int NPIX = W * H;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] th = 8'd100;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       s_sof = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eol;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame [NPIX];
    exp_t       exp_q [$];
    logic [7:0] obs_d [NPIX];
    logic       obs_sof [NPIX];
    logic       obs_eol [NPIX];
    int         done_cnt;
    logic       done_last;
    logic       c_to;
    logic       stall_stable;
    logic       stall_srdy_low;

    aa_stream_filter #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .th      (th),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sof   (s_sof),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int model_px(input int r, input int c);
        int cc, sum;
        int nb [8];
        int nn;
        bit low;
        cc = frame[r*W + c];
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return cc;
        nb[0] = frame[(r-1)*W + c];
        nb[1] = frame[(r+1)*W + c];
        nb[2] = frame[r*W + c - 1];
        nb[3] = frame[r*W + c + 1];
`ifdef AA_DIAG_EN
        nb[4] = frame[(r-1)*W + c - 1];
        nb[5] = frame[(r-1)*W + c + 1];
        nb[6] = frame[(r+1)*W + c - 1];
        nb[7] = frame[(r+1)*W + c + 1];
        nn = 8;
        sum = 8 * cc;
`else
        nn = 4;
        sum = 4 * cc;
`endif
        low = 0;
        for (int i = 0; i < nn; i++) begin
            if (nb[i] <= int'(th)) low = 1;
            sum += nb[i];
        end
        if (!(cc > int'(th) && low)) return cc;
`ifdef AA_DIAG_EN
        return (sum >> 4) & 255;
`else
        return (sum >> 3) & 255;
`endif
    endfunction

    task automatic drive(input int n, output bit to);
        to = 0;
        if (n == NPIX) begin
            for (int i = 0; i < NPIX; i++) begin
                exp_t e;
                e.d   = 8'(model_px(i / W, i % W));
                e.sof = (i == 0);
                e.eol = ((i % W) == W-1);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < n && !to; i++) begin
            bit ok = 0;
            int budget = 0;
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = frame[i];
            s_sof   = (i == 0);
            while (!ok && !to) begin
                #4;
                ok = s_ready;
                @(posedge clk);
                if (!ok) begin
                    @(negedge clk);
                    budget++;
                    if (budget > 200) to = 1;
                end
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic collect(input int n, input int stall_at);
        int got = 0;
        int cyc = 0;
        logic [7:0] hold_d;
        logic hold_sof, hold_eol;
        done_cnt = 0;
        stall_stable = 1'b1;
        stall_srdy_low = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            obs_d[i] = 'x;
            obs_sof[i] = 1'bx;
            obs_eol[i] = 1'bx;
        end
        while (got < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done) done_cnt++;
            if (m_valid && got == stall_at) begin
                m_ready = 1'b0;
                hold_d = m_data;
                hold_sof = m_sof;
                hold_eol = m_eol;
                repeat (5) begin
                    @(negedge clk);
                    cyc++;
                    if (done) done_cnt++;
                    if (m_valid !== 1'b1 || m_data !== hold_d || m_sof !== hold_sof ||
                        m_eol !== hold_eol) stall_stable = 1'b0;
                    if (s_ready !== 1'b0) stall_srdy_low = 1'b0;
                end
                m_ready = 1'b1;
            end
            if (m_valid && m_ready) begin
                obs_d[got] = m_data;
                obs_sof[got] = m_sof;
                obs_eol[got] = m_eol;
                got++;
            end
        end
        c_to = (got < n);
        @(negedge clk);
        done_last = done;
        if (done) done_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'd0 || m_sof !== 1'b0 ||
            m_eol !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: s_ready=%b m_valid=%b m_data=%0d m_sof=%b m_eol=%b done=%b, expected all 0",
                     s_ready, m_valid, m_data, m_sof, m_eol, done);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: s_ready=%b m_valid=%b, expected 1 0", s_ready, m_valid);
        end
    endtask

    task automatic test_uniform(input logic [7:0] v, input string name);
        bit dto;
        for (int i = 0; i < NPIX; i++) frame[i] = v;
        fork
            drive(NPIX, dto);
            collect(NPIX, -1);
        join
        for (int i = 0; i < NPIX; i++) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_d[i] !== e.d || obs_sof[i] !== e.sof || obs_eol[i] !== e.eol) begin
                errors++;
                $display("FAIL %s px%0d: got d=%0d sof=%b eol=%b, expected d=%0d sof=%b eol=%b",
                         name, i, obs_d[i], obs_sof[i], obs_eol[i], e.d, e.sof, e.eol);
            end
        end
        checks++;
        if (done_last !== 1'b1 || done_cnt != 1 || dto || c_to) begin
            errors++;
            $display("FAIL %s done: done_after_last=%b pulses=%0d timeouts=%b%b, expected 1 1 00",
                     name, done_last, done_cnt, dto, c_to);
        end
    endtask

    task automatic test_single_edge();
        bit dto;
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd0;
        frame[1*W + 1] = 8'd200;
        fork
            drive(NPIX, dto);
            collect(NPIX, -1);
        join
        for (int i = 0; i < NPIX; i++) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_d[i] !== e.d || obs_sof[i] !== e.sof || obs_eol[i] !== e.eol) begin
                errors++;
                $display("FAIL single_edge px%0d: got d=%0d sof=%b eol=%b, expected d=%0d sof=%b eol=%b",
                         i, obs_d[i], obs_sof[i], obs_eol[i], e.d, e.sof, e.eol);
            end
        end
        checks++;
        if (obs_d[1*W + 1] !== 8'd100) begin
            errors++;
            $display("FAIL single_edge centre: got %0d, expected 100", obs_d[1*W + 1]);
        end
        checks++;
        if (done_last !== 1'b1 || done_cnt != 1 || dto || c_to) begin
            errors++;
            $display("FAIL single_edge done: done_after_last=%b pulses=%0d timeouts=%b%b, expected 1 1 00",
                     done_last, done_cnt, dto, c_to);
        end
    endtask

    task automatic test_backpressure();
        bit dto;
        for (int i = 0; i < NPIX; i++) frame[i] = 8'(i * 13 + 20);
        frame[5] = 8'd230;
        fork
            drive(NPIX, dto);
            collect(NPIX, 6);
        join
        for (int i = 0; i < NPIX; i++) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_d[i] !== e.d || obs_sof[i] !== e.sof || obs_eol[i] !== e.eol) begin
                errors++;
                $display("FAIL backpressure px%0d: got d=%0d sof=%b eol=%b, expected d=%0d sof=%b eol=%b",
                         i, obs_d[i], obs_sof[i], obs_eol[i], e.d, e.sof, e.eol);
            end
        end
        checks++;
        if (stall_stable !== 1'b1 || stall_srdy_low !== 1'b1) begin
            errors++;
            $display("FAIL backpressure stall: outputs_stable=%b s_ready_low=%b, expected 1 1",
                     stall_stable, stall_srdy_low);
        end
        checks++;
        if (done_last !== 1'b1 || done_cnt != 1 || m_valid !== 1'b0 || dto || c_to) begin
            errors++;
            $display("FAIL backpressure done: done_after_last=%b pulses=%0d m_valid=%b timeouts=%b%b, expected 1 1 0 00",
                     done_last, done_cnt, m_valid, dto, c_to);
        end
    endtask

    task automatic test_mid_reset();
        bit dto;
        for (int i = 0; i < NPIX; i++) frame[i] = 8'd50;
        drive(10, dto);
        checks++;
        if (m_valid !== 1'b1 || dto) begin
            errors++;
            $display("FAIL mid_reset pre: m_valid=%b timeout=%b, expected 1 0", m_valid, dto);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'd0 || m_sof !== 1'b0 || m_eol !== 1'b0 ||
            done !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset clear: m_valid=%b m_data=%0d m_sof=%b m_eol=%b done=%b s_ready=%b, expected all 0",
                     m_valid, m_data, m_sof, m_eol, done, s_ready);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        test_uniform(8'd50, "after_reset");
    endtask

    initial begin
        test_reset();
        test_uniform(8'd50, "uniform50");
        test_single_edge();
        test_uniform(8'd200, "uniform200");
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
